// File: rtl/ghash_formatter.sv
// GHASH input formatter: merges the AAD and ciphertext streams into one padded
// block stream and appends the len(A)||len(C) block, flagged as last.
module ghash_formatter #(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic         no_aad_i,
  input  logic         no_ct_i,
  input  logic [127:0] aad_data_i,
  input  logic [4:0]   aad_bytes_i,
  input  logic         aad_last_i,
  input  logic         aad_valid_i,
  output logic         aad_ready_o,
  input  logic [127:0] ct_data_i,
  input  logic [4:0]   ct_bytes_i,
  input  logic         ct_last_i,
  input  logic         ct_valid_i,
  output logic         ct_ready_o,
  output logic [127:0] dout_o,
  output logic         dout_last_o,
  output logic         dout_valid_o,
  input  logic         dout_ready_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o
);

  typedef enum logic [2:0] {S_IDLE, S_AAD, S_CT, S_LEN, S_FLUSH} state_t;

  state_t             state;
  logic               no_ct_q;
  logic [LEN_W-1:0]   len_a, len_c, len_sel;
  logic               free, acc, is_ct, in_last, bad;
  logic [127:0]       in_data, mask;
  logic [4:0]         in_bytes, eff;
  logic [LEN_W:0]     sum;

  // The output register is free when empty or draining this cycle.
  assign free        = !dout_valid_o || dout_ready_i;
  assign aad_ready_o = (state == S_AAD) && free;
  assign ct_ready_o  = (state == S_CT) && free;
  assign busy_o      = (state != S_IDLE);

  assign is_ct    = (state == S_CT);
  assign in_data  = is_ct ? ct_data_i  : aad_data_i;
  assign in_bytes = is_ct ? ct_bytes_i : aad_bytes_i;
  assign in_last  = is_ct ? ct_last_i  : aad_last_i;
  assign acc      = (aad_valid_i && aad_ready_o) || (ct_valid_i && ct_ready_o);

  // Out-of-range byte counts are processed as a full block.
  assign bad  = (in_bytes == 5'd0) || (in_bytes > 5'd16);
  assign eff  = bad ? 5'd16 : in_bytes;
  assign mask = ~({128{1'b1}} >> {eff, 3'b000});

  assign len_sel = is_ct ? len_c : len_a;
  assign sum     = {1'b0, len_sel} + (LEN_W+1)'({eff, 3'b000});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      no_ct_q      <= 1'b0;
      len_a        <= '0;
      len_c        <= '0;
      dout_o       <= '0;
      dout_last_o  <= 1'b0;
      dout_valid_o <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (dout_valid_o && dout_ready_i) begin
        dout_valid_o <= 1'b0;
        dout_last_o  <= 1'b0;
      end
      case (state)
        S_IDLE: if (start_i) begin
          len_a   <= '0;
          len_c   <= '0;
          err_o   <= 1'b0;
          no_ct_q <= no_ct_i;
          state   <= !no_aad_i ? S_AAD : (!no_ct_i ? S_CT : S_LEN);
        end
        S_AAD, S_CT: if (acc) begin
          dout_o       <= in_data & mask;
          dout_valid_o <= 1'b1;
          dout_last_o  <= 1'b0;
          if (is_ct) len_c <= sum[LEN_W-1:0];
          else       len_a <= sum[LEN_W-1:0];
          if (bad || sum[LEN_W] || (!in_last && eff != 5'd16)) err_o <= 1'b1;
          if (in_last) state <= (is_ct || no_ct_q) ? S_LEN : S_CT;
        end
        S_LEN: if (free) begin
          dout_o       <= {64'(len_a), 64'(len_c)};
          dout_valid_o <= 1'b1;
          dout_last_o  <= 1'b1;
          state        <= S_FLUSH;
        end
        S_FLUSH: if (dout_valid_o && dout_ready_i) begin
          done_o <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ghash_formatter.sv
// Directed bench for ghash_formatter: captured output blocks are compared
// against hand-computed padded blocks and length blocks.
module tb_ghash_formatter;
  logic         clk = 1'b0, rst = 1'b1;
  logic         start_i = 0, no_aad_i = 0, no_ct_i = 0;
  logic [127:0] aad_data_i = '0, ct_data_i = '0;
  logic [4:0]   aad_bytes_i = '0, ct_bytes_i = '0;
  logic         aad_last_i = 0, aad_valid_i = 0, ct_last_i = 0, ct_valid_i = 0;
  logic         aad_ready_o, ct_ready_o;
  logic [127:0] dout_o;
  logic         dout_last_o, dout_valid_o, dout_ready_i = 1;
  logic         busy_o, done_o, err_o;

  ghash_formatter #(.LEN_W(64)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .no_aad_i(no_aad_i), .no_ct_i(no_ct_i),
    .aad_data_i(aad_data_i), .aad_bytes_i(aad_bytes_i), .aad_last_i(aad_last_i),
    .aad_valid_i(aad_valid_i), .aad_ready_o(aad_ready_o),
    .ct_data_i(ct_data_i), .ct_bytes_i(ct_bytes_i), .ct_last_i(ct_last_i),
    .ct_valid_i(ct_valid_i), .ct_ready_o(ct_ready_o),
    .dout_o(dout_o), .dout_last_o(dout_last_o), .dout_valid_o(dout_valid_o),
    .dout_ready_i(dout_ready_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [127:0] got_q[$], exp_q[$];
  logic         got_l[$], exp_l[$];
  int           done_cnt = 0;
  bit           aad_seen = 0;

  localparam logic [127:0] A0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] A1 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [127:0] C0 = 128'hcafebabe_deadbeef_01234567_89abcdef;
  localparam logic [127:0] C1 = 128'h13579bdf_2468ace0_fedcba98_76543210;

  // Inputs change at posedge+1, so the negedge sees settled handshakes.
  always @(negedge clk) if (!rst) begin
    if (dout_valid_o && dout_ready_i) begin
      got_q.push_back(dout_o);
      got_l.push_back(dout_last_o);
    end
    if (done_o) done_cnt++;
    if (aad_ready_o) aad_seen = 1;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic start_msg(input bit na, input bit nc);
    @(posedge clk); #1;
    got_q.delete(); got_l.delete(); exp_q.delete(); exp_l.delete();
    done_cnt = 0; aad_seen = 0;
    start_i = 1; no_aad_i = na; no_ct_i = nc;
    @(posedge clk); #1;
    start_i = 0;
  endtask

  task automatic send(input bit ct, input logic [127:0] d, input logic [4:0] b, input bit l);
    bit ok = 0;
    if (ct) begin ct_data_i = d; ct_bytes_i = b; ct_last_i = l; ct_valid_i = 1; end
    else begin aad_data_i = d; aad_bytes_i = b; aad_last_i = l; aad_valid_i = 1; end
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = ct ? ct_ready_o : aad_ready_o;
    end
    if (!ok) chk("send_timeout", {127'd0, ok}, 128'd1);
    @(posedge clk); #1;
    ct_valid_i = 0; aad_valid_i = 0;
  endtask

  task automatic expect_blk(input logic [127:0] d, input bit l);
    exp_q.push_back(d);
    exp_l.push_back(l);
  endtask

  task automatic finish_msg(input string tag);
    for (int i = 0; i < 100 && done_cnt == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk({tag, "_done"}, 128'(done_cnt), 128'd1);
    chk({tag, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) begin
        chk($sformatf("%s_blk%0d", tag, i), got_q[i], exp_q[i]);
        chk($sformatf("%s_last%0d", tag, i), 128'(got_l[i]), 128'(exp_l[i]));
      end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dout"}, dout_o, 128'd0);
    chk({tag, "_ctl"}, 128'({dout_valid_o, dout_last_o, aad_ready_o, ct_ready_o,
                              busy_o, done_o, err_o}), 128'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 chk_all_zero("reset");
    rst = 0;

    // 1: basic message
    start_msg(0, 0);
    send(0, A0, 16, 0); send(0, A1, 16, 1); send(1, C0, 16, 1);
    expect_blk(A0, 0); expect_blk(A1, 0); expect_blk(C0, 0);
    expect_blk(128'h0000_0000_0000_0100_0000_0000_0000_0080, 1);
    finish_msg("basic");
    chk("basic_err", 128'(err_o), 128'd0);
    chk("basic_busy", 128'(busy_o), 128'd0);

    // 2: partial padding
    start_msg(0, 0);
    send(0, {40'h0102030405, {88{1'b1}}}, 5, 1);
    send(1, C1, 16, 0);
    send(1, {32'hdeadbeef, {96{1'b1}}}, 4, 1);
    expect_blk({40'h0102030405, 88'h0}, 0);
    expect_blk(C1, 0);
    expect_blk({32'hdeadbeef, 96'h0}, 0);
    expect_blk({64'd40, 64'd160}, 1);
    finish_msg("pad");
    chk("pad_err", 128'(err_o), 128'd0);

    // 3a: both streams empty
    start_msg(1, 1);
    expect_blk(128'd0, 1);
    finish_msg("empty");
    // 3b: CT only
    start_msg(1, 0);
    send(1, C0, 16, 1);
    expect_blk(C0, 0); expect_blk({64'd0, 64'd128}, 1);
    finish_msg("ctonly");
    chk("ctonly_aad_rdy", 128'(aad_seen), 128'd0);

    // 4: five stalled cycles while A1 sits in the output register
    start_msg(0, 0);
    fork
      begin
        send(0, A0, 16, 0); send(0, A1, 16, 1);
        send(1, C0, 16, 0); send(1, C1, 16, 1);
      end
      begin
        logic [127:0] hold;
        repeat (2) @(posedge clk);
        #1 dout_ready_i = 0;
        @(negedge clk);
        hold = dout_o;
        chk("bp_hold", hold, A1);
        repeat (5) begin
          @(negedge clk);
          chk("bp_stable", dout_o, hold);
          chk("bp_valid", 128'(dout_valid_o), 128'd1);
          chk("bp_ready", 128'({aad_ready_o, ct_ready_o}), 128'd0);
        end
        @(posedge clk); #1 dout_ready_i = 1;
      end
    join
    expect_blk(A0, 0); expect_blk(A1, 0); expect_blk(C0, 0); expect_blk(C1, 0);
    expect_blk({64'd256, 64'd256}, 1);
    finish_msg("bp");

    // 5a: short non-final AAD block, then a CT block with byte count 0
    start_msg(0, 0);
    send(0, 128'haabbccddeeff0011_2233445566778899, 8, 0);
    chk("err_partial", 128'(err_o), 128'd1);
    send(0, A1, 16, 1);
    send(1, C0, 0, 1);
    expect_blk({64'haabbccddeeff0011, 64'h0}, 0);
    expect_blk(A1, 0); expect_blk(C0, 0);
    expect_blk({64'd192, 64'd128}, 1);
    finish_msg("err");
    chk("err_sticky", 128'(err_o), 128'd1);
    // 5b: start clears err; zero byte count sets it again
    start_msg(1, 0);
    chk("err_cleared", 128'(err_o), 128'd0);
    send(1, C1, 0, 1);
    chk("err_zero_bytes", 128'(err_o), 128'd1);
    expect_blk(C1, 0); expect_blk({64'd0, 64'd128}, 1);
    finish_msg("err0");

    // 6: reset while in S_CT with a block held in the output register
    dout_ready_i = 0;
    start_msg(0, 0);
    send(0, A0, 16, 1);
    chk("pre_rst_valid", 128'(dout_valid_o), 128'd1);
    rst = 1;
    #1 chk_all_zero("midrst");
    @(posedge clk); #1;
    rst = 0; dout_ready_i = 1;
    repeat (3) @(negedge clk);
    chk("midrst_no_out", 128'(got_q.size()), 128'd0);
    start_msg(0, 1);
    send(0, {24'habcdef, {104{1'b1}}}, 3, 1);
    expect_blk({24'habcdef, 104'h0}, 0);
    expect_blk({64'd24, 64'd0}, 1);
    finish_msg("fresh");
    chk("fresh_err", 128'(err_o), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
endmodule
